// File: rtl/ssp_pkg.sv
// Shared definitions for the SSP serial clock stage: field widths, reserved
// frame-size floor and FSM state encoding.
package ssp_pkg;
   localparam int SCR_W_DEF = 8;
   localparam int DSS_W_DEF = 4;
   localparam int DSS_MIN   = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_RUN   = 2'd2,
      ST_HOLD  = 2'd3
   } ssp_state_e;
endpackage

// File: rtl/ssp_rate_cntr.sv
// Serial clock rate counter: counts prescaled enables and emits a half-bit
// tick every (SCR+1) of them while the frame logic is active.
module ssp_rate_cntr
   import ssp_pkg::*;
#(
   parameter int SCR_W = SCR_W_DEF
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             div,
   input  logic [SCR_W-1:0] scr,
   output logic             half_tick
);
   logic [SCR_W-1:0] cnt_q;
   logic [SCR_W-1:0] cnt_d;

   assign half_tick = en & div & (cnt_q == scr);

   // Held at zero while inactive so every frame starts a fresh half period.
   always_comb begin
      cnt_d = cnt_q;
      if (!en || half_tick) begin
         cnt_d = '0;
      end else if (div) begin
         cnt_d = cnt_q + SCR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/ssp_sclk_gen.sv
// SSP serial clock generator: frames (DSS+1) bits with SPO/SPH clocking and
// issues registered shift/sample/done strobes from the rate counter ticks.
module ssp_sclk_gen
   import ssp_pkg::*;
#(
   parameter int SCR_W = SCR_W_DEF,
   parameter int DSS_W = DSS_W_DEF
)
(
   input  logic             SSPCLK,
   input  logic             SSPRST,
   input  logic             SSESync,
   input  logic             SSPCLKDIV,
   input  logic             SPO,
   input  logic             SPH,
   input  logic [DSS_W-1:0] DSS,
   input  logic [SCR_W-1:0] SCR,
   input  logic             Start,
   output logic             SCLKOut,
   output logic             ShiftEn,
   output logic             SampleEn,
   output logic [DSS_W-1:0] BitCnt,
   output logic             Busy,
   output logic             Done
);
   localparam logic [DSS_W-1:0] DSS_MIN_C = DSS_W'(DSS_MIN);

   ssp_state_e       state_q;
   logic             spo_q;
   logic             sph_q;
   logic [DSS_W-1:0] dss_q;
   logic [SCR_W-1:0] scr_q;
   logic [DSS_W:0]   edge_cnt_q;
   logic             sclk_q;
   logic             shift_q;
   logic             sample_q;
   logic             busy_q;
   logic             done_q;

   logic             half_tick;
   logic             last_edge;
   logic             shift_edge;
   logic [DSS_W-1:0] dss_clamped;

   ssp_rate_cntr #(.SCR_W(SCR_W)) u_rate_cntr (
      .clk       (SSPCLK),
      .rst       (SSPRST),
      .en        (state_q != ST_IDLE),
      .div       (SSPCLKDIV),
      .scr       (scr_q),
      .half_tick (half_tick)
   );

   assign dss_clamped = (DSS < DSS_MIN_C) ? DSS_MIN_C : DSS;
   // Final edge index is 2*(DSS+1)-1, i.e. {DSS, 1}.
   assign last_edge   = (edge_cnt_q == {dss_q, 1'b1});
   assign shift_edge  = edge_cnt_q[0] ^ sph_q;

   always_ff @(posedge SSPCLK or posedge SSPRST) begin
      if (SSPRST) begin
         state_q    <= ST_IDLE;
         spo_q      <= 1'b0;
         sph_q      <= 1'b0;
         dss_q      <= '0;
         scr_q      <= '0;
         edge_cnt_q <= '0;
         sclk_q     <= 1'b0;
         shift_q    <= 1'b0;
         sample_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         shift_q  <= 1'b0;
         sample_q <= 1'b0;
         done_q   <= 1'b0;
         if (state_q != ST_IDLE && !SSESync) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            sclk_q     <= SPO;
            edge_cnt_q <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  sclk_q     <= SPO;
                  edge_cnt_q <= '0;
                  if (Start && SSESync) begin
                     spo_q   <= SPO;
                     sph_q   <= SPH;
                     dss_q   <= dss_clamped;
                     scr_q   <= SCR;
                     busy_q  <= 1'b1;
                     state_q <= ST_SETUP;
                  end
               end
               ST_SETUP, ST_RUN: begin
                  if (half_tick) begin
                     sclk_q   <= ~sclk_q;
                     state_q  <= ST_RUN;
                     sample_q <= ~shift_edge;
                     // With SPH=0 the trailing edge of the last bit has nothing left to drive.
                     shift_q  <= shift_edge & (sph_q | ~last_edge);
                     if (last_edge) begin
                        edge_cnt_q <= '0;
                        state_q    <= ST_HOLD;
                     end else begin
                        edge_cnt_q <= edge_cnt_q + (DSS_W+1)'(1);
                     end
                  end
               end
               ST_HOLD: begin
                  if (half_tick) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign SCLKOut  = sclk_q;
   assign ShiftEn  = shift_q;
   assign SampleEn = sample_q;
   assign BitCnt   = edge_cnt_q[DSS_W:1];
   assign Busy     = busy_q;
   assign Done     = done_q;
endmodule

// File: tb/tb_ssp_sclk_gen.sv
// Randomized bench for ssp_sclk_gen: a tick-index reference model predicts
// every output cycle by cycle, plus per-scenario waveform summaries.
module tb_ssp_sclk_gen;
   logic       SSPCLK = 1'b0;
   logic       SSPRST = 1'b1;
   logic       SSESync = 1'b0;
   logic       SSPCLKDIV = 1'b0;
   logic       SPO = 1'b0;
   logic       SPH = 1'b0;
   logic [3:0] DSS = 4'd0;
   logic [7:0] SCR = 8'd0;
   logic       Start = 1'b0;
   logic       SCLKOut, ShiftEn, SampleEn, Busy, Done;
   logic [3:0] BitCnt;

   int nchk = 0;
   int nfail = 0;

   // reference model state
   logic       m_act, m_spo, m_sph;
   int         m_pulse, m_n, m_scr;
   logic       e_sclk, e_shift, e_samp, e_done, e_busy;
   logic [3:0] e_bit;

   ssp_sclk_gen dut (
      .SSPCLK(SSPCLK), .SSPRST(SSPRST), .SSESync(SSESync), .SSPCLKDIV(SSPCLKDIV),
      .SPO(SPO), .SPH(SPH), .DSS(DSS), .SCR(SCR), .Start(Start),
      .SCLKOut(SCLKOut), .ShiftEn(ShiftEn), .SampleEn(SampleEn), .BitCnt(BitCnt),
      .Busy(Busy), .Done(Done)
   );

   always #5 SSPCLK = ~SSPCLK;

   function automatic logic [8:0] obs();
      return {SCLKOut, ShiftEn, SampleEn, Done, Busy, BitCnt};
   endfunction

   function automatic logic [8:0] expv();
      return {e_sclk, e_shift, e_samp, e_done, e_busy, e_bit};
   endfunction

   function automatic void model_reset();
      m_act = 1'b0; m_pulse = 0;
      e_sclk = 1'b0; e_shift = 1'b0; e_samp = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_bit = 4'd0;
   endfunction

   // Half-bit tick t (1-based) is every (SCR+1)-th enable; ticks 1..2N are
   // SCLK edges 0..2N-1 and tick 2N+1 ends the frame.
   function automatic void model_update();
      int t, k;
      e_shift = 1'b0; e_samp = 1'b0; e_done = 1'b0;
      if (SSPRST) begin
         model_reset();
      end else if (!m_act) begin
         e_sclk = SPO; e_bit = 4'd0; e_busy = 1'b0;
         if (Start && SSESync) begin
            m_act = 1'b1; m_pulse = 0; m_spo = SPO; m_sph = SPH;
            m_n = (DSS < 4'd3) ? 4 : int'(DSS) + 1;
            m_scr = int'(SCR);
            e_busy = 1'b1;
         end
      end else if (!SSESync) begin
         m_act = 1'b0; e_busy = 1'b0; e_sclk = SPO; e_bit = 4'd0;
      end else if (SSPCLKDIV) begin
         m_pulse++;
         if (m_pulse % (m_scr + 1) == 0) begin
            t = m_pulse / (m_scr + 1);
            if (t <= 2 * m_n) begin
               k = t - 1;
               e_sclk = m_spo ^ (k % 2 == 0);
               if ((k % 2 == 0) == (m_sph == 1'b0)) e_samp = 1'b1;
               else if (k != 2 * m_n - 1 || m_sph) e_shift = 1'b1;
               e_bit = (k == 2 * m_n - 1) ? 4'd0 : 4'((k + 1) / 2);
            end else begin
               e_done = 1'b1; e_busy = 1'b0; m_act = 1'b0; e_bit = 4'd0;
            end
         end
      end
   endfunction

   task automatic step(input logic st, input logic dv, input logic sse);
      Start = st; SSPCLKDIV = dv; SSESync = sse;
      @(posedge SSPCLK);
      model_update();
      #1;
      Start = 1'b0;
   endtask

   task automatic test_reset();
      SPO = 1'b1;
      repeat (3) @(posedge SSPCLK);
      #1;
      nchk++;
      if (obs() !== 9'd0) begin
         nfail++; $display("FAIL reset_outputs got=%h exp=%h", obs(), 9'd0);
      end
      model_reset();
      SSPRST = 1'b0;
      step(1'b0, 1'b0, 1'b1);
      nchk++;
      if (obs() !== expv()) begin
         nfail++; $display("FAIL reset_idle_spo got=%h exp=%h", obs(), expv());
      end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      int edges = 0, srise = 0, shifts = 0, done_at = -1, last_edge_at = -1;
      logic prev;
      SCR = 8'd0; DSS = 4'd7; SPO = 1'b0; SPH = 1'b0;
      step(1'b0, 1'b1, 1'b1);
      prev = SCLKOut;
      for (int i = 1; i <= 60 && done_at < 0; i++) begin
         step(i == 1, 1'b1, 1'b1);
         nchk++;
         if (obs() !== expv()) begin
            nfail++; $display("FAIL basic_cycle%0d got=%h exp=%h", i, obs(), expv());
         end
         if (SCLKOut !== prev) begin edges++; last_edge_at = i; end
         if (SampleEn && SCLKOut && !prev) srise++;
         if (ShiftEn) shifts++;
         if (Done) done_at = i;
         prev = SCLKOut;
      end
      nchk++; if (edges != 16) begin nfail++; $display("FAIL basic_edges got=%0d exp=16", edges); end
      nchk++; if (srise != 8) begin nfail++; $display("FAIL basic_sample_rise got=%0d exp=8", srise); end
      nchk++; if (shifts != 7) begin nfail++; $display("FAIL basic_shifts got=%0d exp=7", shifts); end
      nchk++; if (last_edge_at != 17) begin nfail++; $display("FAIL basic_last_edge got=%0d exp=17", last_edge_at); end
      nchk++; if (done_at != 18) begin nfail++; $display("FAIL basic_done_at got=%0d exp=18", done_at); end
      $display("test_basic edges=%0d done_at=%0d", edges, done_at);
   endtask

   task automatic test_slow();
      int sfall = 0, srise = 0, maxbit = 0, last_tog = -1, bad_gap = 0, done_at = -1;
      logic prev;
      SCR = 8'd2; DSS = 4'd3; SPO = 1'b1; SPH = 1'b1;
      step(1'b0, 1'b0, 1'b1);
      prev = SCLKOut;
      nchk++; if (SCLKOut !== 1'b1) begin nfail++; $display("FAIL slow_idle_level got=%b exp=1", SCLKOut); end
      for (int i = 1; i <= 120 && done_at < 0; i++) begin
         step(i == 1, (i % 2 == 0), 1'b1);
         nchk++;
         if (obs() !== expv()) begin
            nfail++; $display("FAIL slow_cycle%0d got=%h exp=%h", i, obs(), expv());
         end
         if (SCLKOut !== prev) begin
            if (last_tog >= 0 && i - last_tog != 6) bad_gap++;
            last_tog = i;
         end
         if (ShiftEn && !SCLKOut && prev) sfall++;
         if (SampleEn && SCLKOut && !prev) srise++;
         if (int'(BitCnt) > maxbit) maxbit = int'(BitCnt);
         if (Done) done_at = i;
         prev = SCLKOut;
      end
      nchk++; if (bad_gap != 0) begin nfail++; $display("FAIL slow_half_period bad_gaps=%0d exp=0", bad_gap); end
      nchk++; if (sfall != 4) begin nfail++; $display("FAIL slow_shift_fall got=%0d exp=4", sfall); end
      nchk++; if (srise != 4) begin nfail++; $display("FAIL slow_sample_rise got=%0d exp=4", srise); end
      nchk++; if (maxbit != 3) begin nfail++; $display("FAIL slow_max_bitcnt got=%0d exp=3", maxbit); end
      nchk++; if (done_at < 0) begin nfail++; $display("FAIL slow_done got=none exp=done"); end
      $display("test_slow done_at=%0d", done_at);
   endtask

   task automatic test_reserved();
      int edges = 0, done_at = -1;
      logic prev;
      SCR = 8'($urandom_range(0, 3)); DSS = 4'd1; SPO = 1'($urandom); SPH = 1'($urandom);
      step(1'b0, 1'b0, 1'b1);
      prev = SCLKOut;
      for (int i = 1; i <= 400 && done_at < 0; i++) begin
         step(i == 1, 1'($urandom), 1'b1);
         nchk++;
         if (obs() !== expv()) begin
            nfail++; $display("FAIL reserved_cycle%0d got=%h exp=%h", i, obs(), expv());
         end
         if (SCLKOut !== prev) edges++;
         if (Done) done_at = i;
         prev = SCLKOut;
      end
      nchk++; if (edges != 8 || done_at < 0) begin
         nfail++; $display("FAIL reserved_edges got=%0d done_at=%0d exp=8", edges, done_at);
      end
      $display("test_reserved scr=%0d edges=%0d", SCR, edges);
   endtask

   task automatic test_midchange();
      int edges, done_at, exp_edges;
      logic prev;
      for (int f = 0; f < 2; f++) begin
         edges = 0; done_at = -1;
         if (f == 0) begin SCR = 8'd1; DSS = 4'd5; SPO = 1'b0; SPH = 1'b0; end
         else begin SCR = 8'($urandom_range(0, 2)); DSS = 4'($urandom_range(3, 9)); SPO = 1'($urandom); end
         exp_edges = 2 * (int'(DSS) + 1);
         step(1'b0, 1'b0, 1'b1);
         prev = SCLKOut;
         for (int i = 1; i <= 200 && done_at < 0; i++) begin
            step(i == 1, 1'b1, 1'b1);
            nchk++;
            if (obs() !== expv()) begin
               nfail++; $display("FAIL midchange_f%0d_cycle%0d got=%h exp=%h", f, i, obs(), expv());
            end
            if (SCLKOut !== prev) edges++;
            if (Done) done_at = i;
            prev = SCLKOut;
            if (f == 0 && !Done) begin
               SCR = 8'($urandom); DSS = 4'($urandom); SPO = 1'($urandom); SPH = 1'($urandom);
            end
         end
         nchk++; if (edges != exp_edges || done_at < 0) begin
            nfail++; $display("FAIL midchange_f%0d_edges got=%0d exp=%0d", f, edges, exp_edges);
         end
         $display("test_midchange frame=%0d edges=%0d", f, edges);
      end
   endtask

   task automatic test_abort();
      int edges = 0, guard = 0, dones = 0;
      logic prev;
      SCR = 8'd0; DSS = 4'd7; SPO = 1'($urandom); SPH = 1'($urandom);
      step(1'b0, 1'b0, 1'b1);
      prev = SCLKOut;
      step(1'b1, 1'b1, 1'b1);
      while (edges < 6 && guard < 50) begin
         step(1'b0, 1'b1, 1'b1);
         if (SCLKOut !== prev) edges++;
         prev = SCLKOut;
         guard++;
      end
      nchk++; if (edges != 6) begin nfail++; $display("FAIL abort_reach_edge5 got=%0d exp=6", edges); end
      step(1'b0, 1'b1, 1'b0);
      nchk++;
      if ({Busy, SCLKOut, Done} !== {1'b0, SPO, 1'b0}) begin
         nfail++; $display("FAIL abort_next_cycle got=%b exp=%b", {Busy, SCLKOut, Done}, {1'b0, SPO, 1'b0});
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0);
         nchk++;
         if (obs() !== expv() || Busy !== 1'b0) begin
            nfail++; $display("FAIL abort_start_ignored%0d got=%h exp=%h", i, obs(), expv());
         end
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 1'b1);
         if (Done || ShiftEn || SampleEn) dones++;
      end
      nchk++; if (dones != 0) begin nfail++; $display("FAIL abort_no_strobes got=%0d exp=0", dones); end
      $display("test_abort edges_before_drop=%0d", edges);
   endtask

   task automatic test_rst_mid();
      int dones = 0, edges = 0;
      logic prev;
      SCR = 8'd1; DSS = 4'd4; SPO = 1'b1; SPH = 1'b0;
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
      #3 SSPRST = 1'b1;
      #1;
      nchk++;
      if (obs() !== 9'd0) begin nfail++; $display("FAIL rstmid_immediate got=%h exp=%h", obs(), 9'd0); end
      model_reset();
      step(1'b0, 1'b1, 1'b1);
      nchk++;
      if (obs() !== expv()) begin nfail++; $display("FAIL rstmid_held got=%h exp=%h", obs(), expv()); end
      SSPRST = 1'b0;
      step(1'b0, 1'b0, 1'b1);
      prev = SCLKOut;
      for (int i = 1; i <= 200 && dones == 0; i++) begin
         step(i == 1 || i == 3 || i == 9, 1'b1, 1'b1);
         nchk++;
         if (obs() !== expv()) begin
            nfail++; $display("FAIL rstmid_cycle%0d got=%h exp=%h", i, obs(), expv());
         end
         if (SCLKOut !== prev) edges++;
         if (Done) dones++;
         prev = SCLKOut;
      end
      nchk++; if (dones != 1 || edges != 10) begin
         nfail++; $display("FAIL rstmid_restart dones=%0d edges=%0d exp=1/10", dones, edges);
      end
      $display("test_rst_mid edges=%0d", edges);
   endtask

   task automatic test_random();
      int done_at;
      for (int f = 0; f < 5; f++) begin
         done_at = -1;
         SCR = 8'($urandom_range(0, 7)); DSS = 4'($urandom); SPO = 1'($urandom); SPH = 1'($urandom);
         step(1'b0, 1'($urandom), 1'b1);
         for (int i = 1; i <= 1000 && done_at < 0; i++) begin
            step(i == 1 || ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0), 1'b1);
            nchk++;
            if (obs() !== expv()) begin
               nfail++; $display("FAIL random_f%0d_cycle%0d got=%h exp=%h", f, i, obs(), expv());
            end
            if (Done) done_at = i;
         end
         nchk++; if (done_at < 0) begin nfail++; $display("FAIL random_f%0d_timeout got=none exp=done", f); end
         $display("test_random frame=%0d scr=%0d dss=%0d done_at=%0d", f, SCR, DSS, done_at);
      end
   endtask

   initial begin
      model_reset();
      m_spo = 1'b0; m_sph = 1'b0; m_n = 4; m_scr = 0;
      test_reset();
      test_basic();
      test_slow();
      test_reserved();
      test_midchange();
      test_abort();
      test_rst_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule
